output_wr_buffer: RTL and testbench
===================================

# output_wr_buffer

Write-side buffer directly downstream of the matmul output-control stage. It captures the row writes (address + packed row data) that stage emits and queues them in a small FIFO. It then drains them to the shared memory port over a req/ack handshake, so memory back-pressure never stalls or corrupts output readout. It also signals when a whole output matrix has been committed.

## Interface
- `WORD_SIZE`, 16, bits per output element
- `COLS`, 4, elements per row; `` `MEM_PORT_WIDTH `` from `header_ws.vh` must be ≥ COLS*WORD_SIZE
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `ADDR_WIDTH`, 32, memory address width
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_wr_en`  in  1  write request from output control (may be held high for several cycles)
- `in_addr`  in  ADDR_WIDTH  row address
- `in_data`  in  `MEM_PORT_WIDTH` signed  packed row data
- `in_flush`  in  1  end-of-matrix marker (upstream "write done"), single-cycle pulse
- `mem_req`  out  1  write request to memory
- `mem_addr`  out  ADDR_WIDTH  address of head entry
- `mem_data`  out  `MEM_PORT_WIDTH`  data of head entry
- `mem_ack`  in  1  memory accepted current request
- `buf_full`, `buf_empty`  out  1  FIFO status
- `entries`  out  $clog2(DEPTH)+1  occupancy
- `overflow`  out  1  sticky: a write was dropped
- `drain_done`  out  1  one-cycle pulse: matrix fully committed

## Operation
- Capture rule: on a clock edge with `in_wr_en`=1, push {in_addr, in_data} iff no address is held since the last reset/drain_done, or `in_addr` ≠ last captured address. The last captured address is updated on every push. Repeated same-address cycles are dropped silently; they are not an overflow.
- Push when full with no pop on the same edge: entry is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop on the same edge when full: both take effect; occupancy is unchanged; no overflow.
- Drain FSM states: IDLE, REQ, DONE.
  - IDLE: `mem_req`=0. If not empty → REQ. Else if flush pending → DONE.
  - REQ: `mem_req`=1 with `mem_addr`/`mem_data` = head, held stable until `mem_ack`. On ack, pop. Then go to REQ if more entries remain after the pop, else IDLE.
  - DONE: `drain_done`=1 for one cycle. Clear flush-pending and last-address-valid. → IDLE.
- `in_flush` sets flush-pending. A flush arriving while already pending is merged.
- Data is passed through unmodified; no arithmetic on data. Address compare is a full ADDR_WIDTH equality.

## Timing
- Reset (async assert, sync release): `mem_req`=0, `mem_addr`=0, `mem_data`=0, `buf_empty`=1, `buf_full`=0, `entries`=0, `overflow`=0, `drain_done`=0, FSM=IDLE, flush-pending=0. Reset mid-request drops `mem_req` immediately and discards all entries.
- Latency: push at edge N into an empty FIFO → `mem_req`=1 after edge N+1. No fall-through bypass.
- `mem_ack` is sampled only while `mem_req`=1. With `mem_ack` tied high, throughput is one entry per cycle (back-to-back REQ).
- After the last ack at edge M, with flush pending: IDLE after M, DONE after M+1, `drain_done` high for the cycle after M+1. If flush arrives after the FIFO is already empty, `drain_done` follows two edges later.
- Status outputs (`entries`, `buf_full`, `buf_empty`) are registered and reflect the state after each edge.

## Structure
- Shared package `matmul_pkg`: typedef `wr_entry_t` {addr, data}, plus the MEM_PORT_WIDTH / OUTPUT_MAT_BASE_ADDR / MEM_ADDR_INCR constants migrated from `header_ws.vh`.
- One sub-module, `sync_fifo`, parameterised on the entry type and DEPTH. It provides push, pop, full, empty and count, with simultaneous push/pop. Capture and drain logic stay in the top.

## Test plan
Bench settings: OUTPUT_MAT_BASE_ADDR=0x100, MEM_ADDR_INCR=4, DEPTH=4.
- Four distinct writes (0x100..0x10C, data 0x1..0x4), each held 2 cycles, `mem_ack` tied 1 → exactly four mem writes in order, then in_flush → one `drain_done` pulse; `overflow`=0.
- Same stimulus with `mem_ack` after 3 cycles of `mem_req` → `mem_addr`/`mem_data` stable throughout each request, order preserved, `entries` peaks at 3 or 4.
- `mem_ack`=0, five distinct addresses → `buf_full`=1 after the 4th, 5th dropped, `overflow`=1. Release ack → only 4 writes reach memory.
- `in_wr_en` held 10 cycles at 0x100 → exactly one entry. After `drain_done`, the same address 0x100 is accepted again.
- FIFO full, with push and ack on the same edge → `entries` stays 4 and `overflow` stays 0.
- `rst_n` pulled low during REQ with 3 entries queued → `mem_req` low asynchronously, `entries`=0, no `drain_done` after release.

Source files
------------

// File: rtl/output_wr_buffer_pkg.sv
// Shared matmul definitions: memory-port geometry, output placement and the
// write-buffer entry/state types.
package matmul_pkg;

  localparam int unsigned MEM_PORT_WIDTH = 64;
  localparam int unsigned MEM_ADDR_WIDTH = 32;

  localparam logic [MEM_ADDR_WIDTH-1:0] OUTPUT_MAT_BASE_ADDR = 32'h0000_0100;
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR_INCR        = 32'd4;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_PORT_WIDTH-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } drain_state_e;

endpackage

// File: rtl/output_wr_buffer_sync_fifo.sv
// Single-clock FIFO of generic entries with simultaneous push/pop.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Effective push/pop and next pointer/occupancy values
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/output_wr_buffer.sv
// Write-side buffer behind the matmul output-control stage: captures row
// writes (dropping same-address repeats), queues them and drains them to
// memory over req/ack, pulsing drain_done once a flushed matrix is committed.
module output_wr_buffer
  import matmul_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_wr_en,
  input  logic [ADDR_WIDTH-1:0]             in_addr,
  input  logic signed [MEM_PORT_WIDTH-1:0]  in_data,
  input  logic                              in_flush,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [MEM_PORT_WIDTH-1:0]         mem_data,
  input  logic                              mem_ack,
  output logic                              buf_full,
  output logic                              buf_empty,
  output logic [$clog2(DEPTH):0]            entries,
  output logic                              overflow,
  output logic                              drain_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (COLS * WORD_SIZE > MEM_PORT_WIDTH) begin : g_row_too_wide
    $error("row of COLS*WORD_SIZE bits does not fit the memory port");
  end
  if (ADDR_WIDTH != MEM_ADDR_WIDTH) begin : g_addr_width
    $error("ADDR_WIDTH must match the shared memory address width");
  end

  drain_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
  logic                   last_valid_q, last_valid_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   overflow_q, overflow_d;

  wr_entry_t              push_entry, head_entry;
  logic                   want_push, push_ok, pop;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  sync_fifo #(
    .T     (wr_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (want_push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture decision: new address (or none held) is pushed; repeats are ignored
  always_comb begin
    want_push       = in_wr_en && (!last_valid_q || (in_addr != last_addr_q));
    pop             = (state_q == ST_REQ) && mem_ack;
    push_ok         = want_push && (!fifo_full || pop);
    push_entry      = '0;
    push_entry.addr = in_addr;
    push_entry.data = in_data;
  end

  // Drain FSM next state plus capture/flush/overflow bookkeeping
  always_comb begin
    state_d      = state_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    flush_pend_d = flush_pend_q;
    overflow_d   = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)       state_d = ST_REQ;
        else if (flush_pend_q) state_d = ST_DONE;
      end
      ST_REQ: begin
        // Occupancy after this edge counts a push landing alongside the pop
        if (mem_ack) state_d = ((fifo_count > CW'(1)) || push_ok) ? ST_REQ : ST_IDLE;
      end
      ST_DONE: begin
        flush_pend_d = 1'b0;
        last_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush or capture on the DONE edge belongs to the next matrix
    if (in_flush) flush_pend_d = 1'b1;
    if (want_push) begin
      last_addr_d  = in_addr;
      last_valid_d = 1'b1;
    end
    if (want_push && !push_ok) overflow_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = mem_req ? head_entry.addr : '0;
  assign mem_data   = mem_req ? head_entry.data : '0;
  assign drain_done = (state_q == ST_DONE);
  assign buf_full   = fifo_full;
  assign buf_empty  = fifo_empty;
  assign entries    = fifo_count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_output_wr_buffer.sv
// Scoreboard bench for output_wr_buffer: a capture model queues expected
// memory writes; the monitor compares each handshake and the status outputs.
module tb_output_wr_buffer;
  import matmul_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_wr_en;
  logic [31:0] in_addr;
  logic [63:0] in_data;
  logic        in_flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_ack;
  logic        buf_full, buf_empty;
  logic [2:0]  entries;
  logic        overflow;
  logic        drain_done;

  output_wr_buffer #(
    .WORD_SIZE  (16),
    .COLS       (4),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_wr_en   (in_wr_en),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_flush   (in_flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .buf_full   (buf_full),
    .buf_empty  (buf_empty),
    .entries    (entries),
    .overflow   (overflow),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  wr_entry_t   exp_q[$];
  logic [31:0] m_last;
  bit          m_lv, m_ovf, m_fp;
  int          m_pushes, wr_cnt, drain_cnt, peak;

  // Monitor state
  bit          prev_hold;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;

  task automatic clear_model();
    exp_q.delete();
    m_lv = 0; m_ovf = 0; m_fp = 0; m_pushes = 0;
    wr_cnt = 0; peak = 0;
  endtask

  // Monitor + capture model, evaluated mid-cycle for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      bit        pop, pushed;
      wr_entry_t e;
      chk("entries",  128'(entries), 128'(exp_q.size()));
      chk("buf_full", 128'(buf_full), 128'(exp_q.size() == DEPTH));
      chk("buf_empty", 128'(buf_empty), 128'(exp_q.size() == 0));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (int'(entries) > peak) peak = int'(entries);
      if (prev_hold) begin
        chk("req_held",    128'(mem_req), 128'(1));
        chk("addr_stable", 128'(mem_addr), 128'(prev_addr));
        chk("data_stable", 128'(mem_data), 128'(prev_data));
      end
      if (drain_done) begin
        drain_cnt++;
        chk("drain_needs_flush", 128'(drain_done), 128'(m_fp));
      end
      pop = mem_req && mem_ack;
      if (pop) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("write_while_empty", 128'(mem_req), 128'(0));
        else begin
          chk("wr_addr", 128'(mem_addr), 128'(exp_q[0].addr));
          chk("wr_data", 128'(mem_data), 128'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
      prev_hold = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_data;
      pushed = 0;
      if (in_wr_en && (!m_lv || in_addr != m_last)) begin
        m_last = in_addr;
        m_lv   = 1;
        pushed = 1;
        if (exp_q.size() < DEPTH) begin
          e.addr = in_addr;
          e.data = in_data;
          exp_q.push_back(e);
          m_pushes++;
        end else m_ovf = 1;
      end
      if (drain_done && !pushed) m_lv = 0;
      if (drain_done) m_fp = 0;
      if (in_flush) m_fp = 1;
    end
  end

  // Memory-side ack generator: 0 manual, 1 tied high, 2 after 3 req cycles, 3 random
  int ack_mode = 0;
  int req_run = 0;
  bit a_prev_req = 0, a_prev_ack = 0;
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) req_run = 0;
    else begin
      if (a_prev_req && a_prev_ack) req_run = 0;
      req_run = mem_req ? req_run + 1 : 0;
      case (ack_mode)
        1: mem_ack = 1'b1;
        2: mem_ack = (req_run >= 3);
        default: mem_ack = ($urandom_range(0, 1) == 1);
      endcase
    end
    a_prev_req = mem_req;
    a_prev_ack = mem_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_model();
    #12;
    rst_n = 1;
    step();
  endtask

  task automatic write_row(input logic [31:0] a, input logic [63:0] d, input int hold);
    in_wr_en = 1; in_addr = a; in_data = d;
    repeat (hold) step();
    in_wr_en = 0;
  endtask

  task automatic flush();
    in_flush = 1;
    step();
    in_flush = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || buf_empty !== 1'b1 || mem_req !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 128'(n < budget), 128'(1));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int d0 = drain_cnt;
    int n = 0;
    while (drain_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    chk(name, 128'(drain_cnt - d0), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 0; in_wr_en = 0; in_addr = '0; in_data = '0; in_flush = 0; mem_ack = 0;
    clear_model();
    drain_cnt = 0;
    #3;
    chk("rst_mem_req",    128'(mem_req), 128'(0));
    chk("rst_mem_addr",   128'(mem_addr), 128'(0));
    chk("rst_mem_data",   128'(mem_data), 128'(0));
    chk("rst_buf_empty",  128'(buf_empty), 128'(1));
    chk("rst_buf_full",   128'(buf_full), 128'(0));
    chk("rst_entries",    128'(entries), 128'(0));
    chk("rst_overflow",   128'(overflow), 128'(0));
    chk("rst_drain_done", 128'(drain_done), 128'(0));
    #10;
    rst_n = 1;
    step();

    // Four rows, ack tied high, then flush into an empty buffer
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 4; i++)
      write_row(OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'(i), 64'(i + 1), 2);
    wait_idle("s1_drain_timeout", 40);
    chk("s1_writes", 128'(wr_cnt), 128'(4));
    step(); step();
    d0 = drain_cnt;
    flush();
    @(negedge clk);
    chk("s1_drain_early", 128'(drain_done), 128'(0));
    step();
    @(negedge clk);
    chk("s1_drain_at_2", 128'(drain_done), 128'(1));
    repeat (3) step();
    chk("s1_drain_pulses", 128'(drain_cnt - d0), 128'(1));
    chk("s1_overflow", 128'(overflow), 128'(0));

    // Same rows, memory acks after three cycles of request
    do_reset();
    ack_mode = 2;
    for (int i = 0; i < 4; i++)
      write_row(OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'(i), 64'(i + 1), 2);
    wait_idle("s2_drain_timeout", 80);
    chk("s2_writes", 128'(wr_cnt), 128'(4));
    chk("s2_peak_ge3", 128'(peak >= 3), 128'(1));
    flush();
    wait_drain("s2_drain_pulses", 10);

    // Five rows with memory stalled: fifth is dropped
    do_reset();
    ack_mode = 0; mem_ack = 0;
    for (int i = 0; i < 5; i++)
      write_row(OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'(i), {$urandom, $urandom}, 2);
    @(negedge clk);
    chk("s3_full",     128'(buf_full), 128'(1));
    chk("s3_overflow", 128'(overflow), 128'(1));
    step();
    ack_mode = 1;
    wait_idle("s3_drain_timeout", 40);
    chk("s3_writes", 128'(wr_cnt), 128'(4));
    chk("s3_overflow_sticky", 128'(overflow), 128'(1));

    // Held write enable at one address captures once; re-accepted after drain
    do_reset();
    ack_mode = 1;
    in_wr_en = 1; in_addr = 32'h100; in_data = {$urandom, $urandom};
    step();
    @(negedge clk);
    chk("s4_req_latency0", 128'(mem_req), 128'(0));
    chk("s4_entries1",     128'(entries), 128'(1));
    step();
    @(negedge clk);
    chk("s4_req_latency1", 128'(mem_req), 128'(1));
    repeat (8) step();
    in_wr_en = 0;
    wait_idle("s4_drain_timeout", 20);
    chk("s4_single_write", 128'(wr_cnt), 128'(1));
    flush();
    wait_drain("s4_drain_pulses", 10);
    write_row(32'h100, {$urandom, $urandom}, 1);
    wait_idle("s4_reaccept_timeout", 20);
    chk("s4_reaccepted", 128'(wr_cnt), 128'(2));

    // Full buffer with push and ack on the same edge
    do_reset();
    ack_mode = 0; mem_ack = 0;
    for (int i = 0; i < 4; i++)
      write_row(OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'(i), {$urandom, $urandom}, 1);
    step(); step();
    in_wr_en = 1; in_addr = 32'h200; in_data = {$urandom, $urandom}; mem_ack = 1;
    step();
    in_wr_en = 0; mem_ack = 0;
    @(negedge clk);
    chk("s5_entries",  128'(entries), 128'(4));
    chk("s5_overflow", 128'(overflow), 128'(0));
    step();
    ack_mode = 1;
    wait_idle("s5_drain_timeout", 30);
    chk("s5_writes", 128'(wr_cnt), 128'(5));

    // Reset while a request is outstanding with a flush pending
    do_reset();
    ack_mode = 0; mem_ack = 0;
    for (int i = 0; i < 3; i++)
      write_row(OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'(i), {$urandom, $urandom}, 1);
    flush();
    step();
    #2;
    rst_n = 0;
    clear_model();
    #1;
    chk("s6_req_async",  128'(mem_req), 128'(0));
    chk("s6_entries",    128'(entries), 128'(0));
    chk("s6_empty",      128'(buf_empty), 128'(1));
    chk("s6_drain_low",  128'(drain_done), 128'(0));
    d0 = drain_cnt;
    #10;
    rst_n = 1;
    repeat (6) step();
    chk("s6_no_drain", 128'(drain_cnt - d0), 128'(0));

    // Randomized traffic with repeats, flushes and random memory stalls
    do_reset();
    ack_mode = 3;
    repeat (300) begin
      in_wr_en = ($urandom_range(0, 1) == 1);
      in_addr  = OUTPUT_MAT_BASE_ADDR + MEM_ADDR_INCR * 32'($urandom_range(0, 3));
      in_data  = {$urandom, $urandom};
      in_flush = ($urandom_range(0, 15) == 0);
      step();
    end
    in_wr_en = 0; in_flush = 0;
    ack_mode = 1;
    wait_idle("rand_drain_timeout", 60);
    repeat (4) step();
    chk("rand_all_written", 128'(wr_cnt), 128'(m_pushes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
